// File: rtl/llr_user_scheduler.sv
// llr_user_scheduler: per-symbol user sequencer feeding the slow-PHY-to-LLR converter.
//   i_core_clk / i_rx_rstn        clock, asynchronous active-low reset
//   i_cfg_we/addr/en/rate/re_amts per-user table write port (any time)
//   i_num_users                   users scanned this symbol, sampled on i_sym_start
//   i_sym_start / i_abort         begin / abandon a symbol (one-cycle pulses)
//   i_data_strobe                 converter output strobe, worth 2 REs
//   o_conv_fsm_rstn               converter FSM reset, active low
//   o_user_iq_noise_rate, o_cur_user_re_amounts, o_cur_user_id  shadow copy of user in flight
//   o_user_start/o_user_done/o_sym_done  event pulses; o_busy; o_timeout_err (sticky)
module llr_user_scheduler #(
  parameter int NUM_USERS   = 8,
  parameter int UIDW        = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            i_core_clk,
  input  logic            i_rx_rstn,
  input  logic            i_cfg_we,
  input  logic [UIDW-1:0] i_cfg_addr,
  input  logic            i_cfg_en,
  input  logic [15:0]     i_cfg_rate,
  input  logic [15:0]     i_cfg_re_amounts,
  input  logic [UIDW:0]   i_num_users,
  input  logic            i_sym_start,
  input  logic            i_abort,
  input  logic            i_data_strobe,
  output logic            o_conv_fsm_rstn,
  output logic [15:0]     o_user_iq_noise_rate,
  output logic [15:0]     o_cur_user_re_amounts,
  output logic [UIDW-1:0] o_cur_user_id,
  output logic            o_user_start,
  output logic            o_user_done,
  output logic            o_sym_done,
  output logic            o_busy,
  output logic            o_timeout_err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CLR = 3'd2,
                         S_RUN  = 3'd3, S_NEXT = 3'd4, S_DONE = 3'd5;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [2:0] state;
  logic [NUM_USERS-1:0] tbl_en;
  logic [15:0] tbl_rate [NUM_USERS];
  logic [15:0] tbl_re [NUM_USERS];
  logic [UIDW-1:0] idx;
  logic [UIDW:0] num, idx_inc;
  logic [16:0] re_cnt, re_cnt_inc;
  logic [TW-1:0] to_cnt;
  logic clr_ph, abort_hold, last_user;
  assign idx_inc    = {1'b0, idx} + (UIDW+1)'(1);
  assign re_cnt_inc = re_cnt + 17'd2;
  // the last-index term keeps an out-of-range i_num_users from looping forever
  assign last_user  = (idx_inc >= num) || (idx == UIDW'(NUM_USERS - 1));
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) tbl_en <= '0;
    else if (i_cfg_we) tbl_en[i_cfg_addr] <= i_cfg_en;
  end
  always_ff @(posedge i_core_clk) begin
    if (i_cfg_we) begin
      tbl_rate[i_cfg_addr] <= i_cfg_rate;
      tbl_re[i_cfg_addr]   <= i_cfg_re_amounts;
    end
  end
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state                 <= S_IDLE;
      idx                   <= '0;
      num                   <= '0;
      re_cnt                <= '0;
      to_cnt                <= '0;
      clr_ph                <= 1'b0;
      abort_hold            <= 1'b0;
      o_conv_fsm_rstn       <= 1'b0;
      o_user_iq_noise_rate  <= '0;
      o_cur_user_re_amounts <= '0;
      o_cur_user_id         <= '0;
      o_user_start          <= 1'b0;
      o_user_done           <= 1'b0;
      o_sym_done            <= 1'b0;
      o_busy                <= 1'b0;
      o_timeout_err         <= 1'b0;
    end else begin
      o_user_start    <= 1'b0;
      o_user_done     <= 1'b0;
      o_sym_done      <= 1'b0;
      abort_hold      <= 1'b0;
      // abort_hold stretches the converter reset to a second cycle after an abort
      o_conv_fsm_rstn <= !abort_hold;
      if (i_abort && state != S_IDLE) begin
        state           <= S_IDLE;
        o_busy          <= 1'b0;
        abort_hold      <= 1'b1;
        o_conv_fsm_rstn <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (i_sym_start) begin
            state         <= S_LOAD;
            idx           <= '0;
            num           <= i_num_users;
            o_busy        <= 1'b1;
            o_timeout_err <= 1'b0;
          end
          // a zero-user symbol passes through LOAD so o_sym_done lands 2 cycles after start
          S_LOAD: begin
            o_user_iq_noise_rate  <= tbl_rate[idx];
            o_cur_user_re_amounts <= tbl_re[idx];
            o_cur_user_id         <= idx;
            clr_ph                <= 1'b0;
            if (num == '0) begin
              state      <= S_DONE;
              o_sym_done <= 1'b1;
            end else if (!tbl_en[idx] || tbl_re[idx] == '0) state <= S_NEXT;
            else begin
              state           <= S_CLR;
              o_conv_fsm_rstn <= 1'b0;
            end
          end
          S_CLR: begin
            re_cnt <= '0;
            to_cnt <= '0;
            clr_ph <= 1'b1;
            if (clr_ph) begin
              state        <= S_RUN;
              o_user_start <= 1'b1;
            end else o_conv_fsm_rstn <= 1'b0;
          end
          // o_user_done is raised on the deciding edge; the following RUN cycle hands over to NEXT
          S_RUN: begin
            if (o_user_done) state <= S_NEXT;
            else if (i_data_strobe) begin
              re_cnt <= re_cnt_inc;
              to_cnt <= '0;
              if (re_cnt_inc >= {1'b0, o_cur_user_re_amounts}) o_user_done <= 1'b1;
            end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
              o_user_done   <= 1'b1;
              o_timeout_err <= 1'b1;
            end else to_cnt <= to_cnt + TW'(1);
          end
          S_NEXT: begin
            idx <= idx_inc[UIDW-1:0];
            if (last_user) begin
              state      <= S_DONE;
              o_sym_done <= 1'b1;
            end else state <= S_LOAD;
          end
          S_DONE: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
